bht_update_queue: RTL and testbench
===================================

# bht_update_queue

Branch-resolution side of the local branch history table. It records each predicted branch at fetch (PC plus predicted direction) in a small in-order queue. When execute resolves the oldest branch, it emits the registered BHT update (`write`/`write_pc`/`taken`) and a `mispredict` pulse. On a mispredict it discards all younger, wrong-path entries. It sits between the fetch stage and the execute stage, and drives the BHT's write port.

## Interface
- `DEPTH`, default 4: number of outstanding branches; must be a power of two, ≥ 2.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `push`  in  1  fetch issued a predicted branch this cycle.
- `push_pc`  in  16  (`lc3b_word`) PC of that branch.
- `push_pred`  in  1  predicted direction; 1 = taken.
- `resolve`  in  1  execute resolved the oldest outstanding branch.
- `resolve_taken`  in  1  actual direction of that branch.
- `flush`  in  1  external pipeline flush (e.g. trap/interrupt); discards all entries.
- `full`  out  1  count == DEPTH.
- `empty`  out  1  count == 0.
- `count`  out  $clog2(DEPTH)+1  number of valid entries.
- `write`  out  1  BHT update strobe.
- `write_pc`  out  16  PC of the branch being updated.
- `taken`  out  1  resolved direction for the BHT.
- `mispredict`  out  1  resolved direction ≠ stored prediction.

## Operation
- Circular buffer with head pointer, tail pointer and count. Pointers are log2(DEPTH) bits and wrap naturally.
- Push: when `push` && !`full`, store {`push_pc`, `push_pred`} at the tail, advance tail, count+1. A push while full is dropped and leaves state unchanged. Fetch must stall on `full`.
- Resolve: when `resolve` && !`empty`, read the head entry and advance head, count−1. Register the outputs:
  - `write`=1
  - `write_pc`=head PC
  - `taken`=`resolve_taken`
  - `mispredict`=(head pred ≠ `resolve_taken`)
- Resolve while empty is ignored, and no `write` is produced.
- Mispredict squash: on the edge where a resolve mispredicts, set tail=head+1 and count=0, discarding all younger entries. A `push` in that same cycle is wrong-path and is also discarded.
- Simultaneous push and resolve on a correct prediction: both occur, count unchanged. This is legal when full: the head frees a slot in the same edge.
- `flush` priority is: reset > flush > resolve/push. `flush` sets head=tail and count=0, and produces no `write`/`mispredict` that cycle, even if `resolve` is high.
- `write`, `mispredict` are single-cycle pulses. `write_pc`/`taken` hold their last value until the next update.

## Timing
- Reset values: `count`=0, `empty`=1, `full`=0, `write`=0, `write_pc`=16'h0000, `taken`=0, `mispredict`=0, head=tail=0.
- Storage array contents are don't-care after reset.
- Resolve in cycle N → `write`/`mispredict` high in cycle N+1. The BHT commits at the end of cycle N+1.
- `full`/`empty`/`count` are registered and reflect state after the previous edge. A push in cycle N is visible in `count` in cycle N+1.
- Reset asserted mid-operation: all entries and pending outputs are cleared at that edge. No update is emitted for an in-flight resolve.
- Back-to-back resolves produce back-to-back `write` pulses, with no bubble.

## Configuration
- `BHT_UPDQ_STATS_EN` defined: adds outputs `stat_resolved` [15:0] and `stat_mispredicts` [15:0].
  - Both are saturating counters, cleared by `reset`.
  - They increment on the same edge that sets `write` and `mispredict` respectively, and hold at 16'hFFFF.
- `BHT_UPDQ_STATS_EN` undefined: these ports and counters do not exist. Behaviour of all other ports is identical.

## Structure
- Add to `lc3b_types`: `lc3b_bhtq_entry` struct {`lc3b_word pc`; `logic pred`}.
- Pointer/count widths are derived locally from `DEPTH`.
- One sub-module: `bht_update_queue_array`, a DEPTH×17 register file with synchronous write at tail and combinational read at head. The top level holds the pointers, count, squash logic and output registers.

## Test plan
- Reset, then push pc=0x0100 pred=1, then resolve taken=1 → next cycle `write`=1, `write_pc`=0x0100, `taken`=1, `mispredict`=0; `empty`=1.
- Push 0x0200(pred 0), 0x0210, 0x0220; resolve taken=1 → `mispredict`=1, `write_pc`=0x0200; after the edge `count`=0, and the younger two are never emitted.
- Fill to DEPTH=4, push 0x0300 while full with no resolve → dropped; four resolves emit only the first four PCs, in order.
- Full queue, push 0x0400 and correct resolve in the same cycle → `count` stays 4; 0x0400 emerges as the 4th subsequent update.
- Push two entries, assert `flush` together with `resolve` → no `write` next cycle; `count`=0, `empty`=1.
- Resolve while empty → `write` stays 0. With `BHT_UPDQ_STATS_EN` defined, 3 resolves with 1 mispredict → `stat_resolved`=3, `stat_mispredicts`=1.

Source files
------------

// File: rtl/bht_update_queue_pkg.sv
// Shared types for the branch-resolution queue: the LC-3b word and one queue entry.
// No logic, types and constants only.
// Imported by the queue top, its storage array, its interface and the bench.
package bht_update_queue_pkg;

   typedef logic [15:0] lc3b_word;

   // One outstanding predicted branch, as recorded at fetch.
   typedef struct packed {
      lc3b_word pc;
      logic     pred;
   } lc3b_bhtq_entry;

   localparam int BHTQ_ENTRY_W = $bits(lc3b_bhtq_entry);

endpackage

// File: rtl/bht_update_queue_if.sv
// Fetch/execute/BHT-side bundle of the branch update queue.
// Modports: slave = the queue (consumes push/resolve/flush, drives status and BHT update);
// master = the pipeline side. Optional BHT_UPDQ_STATS_EN adds the two statistics counters.
interface bht_update_queue_if
   import bht_update_queue_pkg::*;
#(
   parameter int DEPTH = 4
);
   // fetch side
   logic                     push;
   lc3b_word                 push_pc;
   logic                     push_pred;
   // execute side
   logic                     resolve;
   logic                     resolve_taken;
   logic                     flush;
   // status
   logic                     full;
   logic                     empty;
   logic [$clog2(DEPTH):0]   count;
   // BHT write port
   logic                     write;
   lc3b_word                 write_pc;
   logic                     taken;
   logic                     mispredict;
`ifdef BHT_UPDQ_STATS_EN
   logic [15:0]              stat_resolved;
   logic [15:0]              stat_mispredicts;
`endif

   modport slave (
      input  push, push_pc, push_pred, resolve, resolve_taken, flush,
      output full, empty, count, write, write_pc, taken, mispredict
`ifdef BHT_UPDQ_STATS_EN
      , output stat_resolved, stat_mispredicts
`endif
   );

   modport master (
      output push, push_pc, push_pred, resolve, resolve_taken, flush,
      input  full, empty, count, write, write_pc, taken, mispredict
`ifdef BHT_UPDQ_STATS_EN
      , input stat_resolved, stat_mispredicts
`endif
   );

endinterface

// File: rtl/bht_update_queue_array.sv
// DEPTH x 17 entry store for the branch update queue: sync write at tail, comb read at head.
// Ports: i_clk, i_we/i_waddr/i_wdata write port; i_raddr/o_rdata read port (0-cycle read).
// No backpressure; the caller only writes when a slot is free. Contents undefined after reset.
module bht_update_queue_array
   import bht_update_queue_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PW    = $clog2(DEPTH)
) (
   input  logic           i_clk,
   input  logic           i_we,
   input  logic [PW-1:0]  i_waddr,
   input  lc3b_bhtq_entry i_wdata,
   input  logic [PW-1:0]  i_raddr,
   output lc3b_bhtq_entry o_rdata
);

   lc3b_bhtq_entry r_mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/bht_update_queue.sv
// In-order queue of predicted branches; emits the registered BHT update when the oldest resolves.
// Latency: resolve in cycle N -> write/mispredict pulse in N+1; count/full/empty reflect the last edge.
// Backpressure: fetch stalls on full (a push while full is dropped unless a correct resolve frees the head).
// Ports: clk, reset (sync, active high), bus (slave modport of bht_update_queue_if).
// Optional macro BHT_UPDQ_STATS_EN adds saturating stat_resolved / stat_mispredicts counters.
module bht_update_queue
   import bht_update_queue_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic               clk,
   input  logic               reset,
   bht_update_queue_if.slave  bus
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0]  r_head;
   logic [PW-1:0]  r_tail;
   logic [CW-1:0]  r_count;
   logic           r_write;
   lc3b_word       r_write_pc;
   logic           r_taken;
   logic           r_mispredict;

   logic           w_full;
   logic           w_empty;
   logic           w_do_resolve;
   logic           w_mispred;
   logic           w_do_push;
   lc3b_bhtq_entry w_head_entry;
   lc3b_bhtq_entry w_push_entry;

   assign w_full  = (r_count == CW'(DEPTH));
   assign w_empty = (r_count == '0);

   // Flush outranks resolve: a flushed cycle never produces an update.
   assign w_do_resolve = bus.resolve && !w_empty && !bus.flush;
   assign w_mispred    = w_do_resolve && (w_head_entry.pred != bus.resolve_taken);

   // A correct resolve frees the head slot on the same edge, so a push into a
   // full queue is accepted then. A push alongside a mispredict is wrong-path.
   assign w_do_push = bus.push && !bus.flush && !w_mispred &&
                      (!w_full || w_do_resolve);

   assign w_push_entry = '{pc: bus.push_pc, pred: bus.push_pred};

   bht_update_queue_array #(
      .DEPTH (DEPTH)
   ) u_array (
      .i_clk   (clk),
      .i_we    (w_do_push && !reset),
      .i_waddr (r_tail),
      .i_wdata (w_push_entry),
      .i_raddr (r_head),
      .o_rdata (w_head_entry)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_head       <= '0;
         r_tail       <= '0;
         r_count      <= '0;
         r_write      <= 1'b0;
         r_write_pc   <= '0;
         r_taken      <= 1'b0;
         r_mispredict <= 1'b0;
      end else if (bus.flush) begin
         r_head       <= r_tail;
         r_count      <= '0;
         r_write      <= 1'b0;
         r_mispredict <= 1'b0;
      end else begin
         r_write      <= w_do_resolve;
         r_mispredict <= w_mispred;
         if (w_do_resolve) begin
            r_write_pc <= w_head_entry.pc;
            r_taken    <= bus.resolve_taken;
         end
         if (w_mispred) begin
            // Everything younger than the resolved branch is wrong-path.
            r_head  <= r_head + PW'(1);
            r_tail  <= r_head + PW'(1);
            r_count <= '0;
         end else begin
            if (w_do_resolve) begin
               r_head <= r_head + PW'(1);
            end
            if (w_do_push) begin
               r_tail <= r_tail + PW'(1);
            end
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_resolve);
         end
      end
   end

   assign bus.full       = w_full;
   assign bus.empty      = w_empty;
   assign bus.count      = r_count;
   assign bus.write      = r_write;
   assign bus.write_pc   = r_write_pc;
   assign bus.taken      = r_taken;
   assign bus.mispredict = r_mispredict;

`ifdef BHT_UPDQ_STATS_EN
   logic [15:0] r_stat_resolved;
   logic [15:0] r_stat_mispredicts;

   // Counters advance on the same edge that raises write / mispredict.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_stat_resolved    <= '0;
         r_stat_mispredicts <= '0;
      end else if (!bus.flush) begin
         if (w_do_resolve && (r_stat_resolved != 16'hFFFF)) begin
            r_stat_resolved <= r_stat_resolved + 16'd1;
         end
         if (w_mispred && (r_stat_mispredicts != 16'hFFFF)) begin
            r_stat_mispredicts <= r_stat_mispredicts + 16'd1;
         end
      end
   end

   assign bus.stat_resolved    = r_stat_resolved;
   assign bus.stat_mispredicts = r_stat_mispredicts;
`endif

endmodule

// File: tb/tb_bht_update_queue.sv
// Bench for bht_update_queue: directed scenarios with literal expectations, then random traffic
// checked each cycle against a queue-based model of the branch list.
// Inputs change 1ns after the rising edge; outputs are compared 1ns after the edge.
module tb_bht_update_queue;
   import bht_update_queue_pkg::*;

   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   bht_update_queue_if #(.DEPTH(DEPTH)) bus ();

   bht_update_queue #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: outstanding branches oldest-first, plus the last update seen by the BHT.
   lc3b_bhtq_entry m_q[$];
   logic     m_write;
   lc3b_word m_pc;
   logic     m_taken;
   logic     m_mis;
   int       m_stat_res;
   int       m_stat_mis;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      chk("count",      32'(bus.count),      32'(m_q.size()));
      chk("empty",      32'(bus.empty),      32'(m_q.size() == 0));
      chk("full",       32'(bus.full),       32'(m_q.size() == DEPTH));
      chk("write",      32'(bus.write),      32'(m_write));
      chk("write_pc",   32'(bus.write_pc),   32'(m_pc));
      chk("taken",      32'(bus.taken),      32'(m_taken));
      chk("mispredict", 32'(bus.mispredict), 32'(m_mis));
`ifdef BHT_UPDQ_STATS_EN
      chk("stat_resolved",    32'(bus.stat_resolved),    32'(m_stat_res > 65535 ? 65535 : m_stat_res));
      chk("stat_mispredicts", 32'(bus.stat_mispredicts), 32'(m_stat_mis > 65535 ? 65535 : m_stat_mis));
`endif
   endtask

   // Apply one cycle of inputs, advance the model by the queue's rules, then compare.
   task automatic step(input logic rst, input logic p, input lc3b_word pc, input logic pd,
                       input logic r, input logic rt, input logic fl);
      lc3b_bhtq_entry e;
      reset             = rst;
      bus.push          = p;
      bus.push_pc       = pc;
      bus.push_pred     = pd;
      bus.resolve       = r;
      bus.resolve_taken = rt;
      bus.flush         = fl;
      @(posedge clk);
      if (rst) begin
         m_q.delete();
         m_write = 0; m_pc = '0; m_taken = 0; m_mis = 0;
         m_stat_res = 0; m_stat_mis = 0;
      end else if (fl) begin
         m_q.delete();
         m_write = 0; m_mis = 0;
      end else begin
         m_write = 0; m_mis = 0;
         if (r && m_q.size() > 0) begin
            e = m_q.pop_front();
            m_write = 1; m_pc = e.pc; m_taken = rt; m_mis = (e.pred != rt);
            m_stat_res++;
            if (m_mis) m_stat_mis++;
         end
         if (m_mis) m_q.delete();
         else if (p && m_q.size() < DEPTH) m_q.push_back('{pc: pc, pred: pd});
      end
      #1;
      compare_all();
   endtask

   task automatic idle();
      step(0, 0, 16'h0, 0, 0, 0, 0);
   endtask

   task automatic push1(input lc3b_word pc, input logic pd);
      step(0, 1, pc, pd, 0, 0, 0);
   endtask

   task automatic res1(input logic rt);
      step(0, 0, 16'h0, 0, 1, rt, 0);
   endtask

   initial begin
      lc3b_word exp_pcs[4];
      logic p, r, rt, fl, rst;
      #1;
      // Reset with push/resolve high: nothing may come out of it.
      step(1, 1, 16'hBEEF, 1, 1, 1, 0);
      step(1, 0, 16'h0, 0, 0, 0, 0);
      chk("rst_count", 32'(bus.count), 0);
      chk("rst_empty", 32'(bus.empty), 1);
      chk("rst_pc",    32'(bus.write_pc), 0);

      // Single correct resolve.
      push1(16'h0100, 1);
      res1(1);
      chk("t1_write", 32'(bus.write), 1);
      chk("t1_pc",    32'(bus.write_pc), 32'h0100);
      chk("t1_taken", 32'(bus.taken), 1);
      chk("t1_mis",   32'(bus.mispredict), 0);
      chk("t1_empty", 32'(bus.empty), 1);

      // Mispredict squashes the younger entries.
      push1(16'h0200, 0);
      push1(16'h0210, 1);
      push1(16'h0220, 1);
      res1(1);
      chk("t2_mis",   32'(bus.mispredict), 1);
      chk("t2_pc",    32'(bus.write_pc), 32'h0200);
      chk("t2_count", 32'(bus.count), 0);
      res1(1);
      chk("t2_nowrite", 32'(bus.write), 0);

      // Fill, drop a push while full, drain in order.
      exp_pcs = '{16'h0310, 16'h0320, 16'h0330, 16'h0340};
      for (int i = 0; i < 4; i++) push1(exp_pcs[i], 1);
      push1(16'h0300, 1);
      chk("t3_full", 32'(bus.full), 1);
      for (int i = 0; i < 4; i++) begin
         res1(1);
         chk("t3_pc", 32'(bus.write_pc), 32'(exp_pcs[i]));
      end
      idle();
      chk("t3_drained", 32'(bus.write), 0);

      // Push plus correct resolve while full.
      for (int i = 0; i < 4; i++) push1(16'h0350 + 16'(i), 1);
      step(0, 1, 16'h0400, 1, 1, 1, 0);
      chk("t4_count", 32'(bus.count), 4);
      for (int i = 0; i < 4; i++) res1(1);
      chk("t4_pc", 32'(bus.write_pc), 32'h0400);

      // Flush wins over resolve.
      push1(16'h0500, 1);
      push1(16'h0510, 1);
      step(0, 0, 16'h0, 0, 1, 1, 1);
      chk("t5_write", 32'(bus.write), 0);
      chk("t5_count", 32'(bus.count), 0);
      chk("t5_empty", 32'(bus.empty), 1);

      // Resolve while empty.
      res1(0);
      chk("t6_write", 32'(bus.write), 0);

`ifdef BHT_UPDQ_STATS_EN
      step(1, 0, 16'h0, 0, 0, 0, 0);
      push1(16'h0600, 1);
      push1(16'h0610, 1);
      push1(16'h0620, 0);
      res1(1);
      res1(1);
      res1(1);
      chk("stat_res3", 32'(bus.stat_resolved), 3);
      chk("stat_mis1", 32'(bus.stat_mispredicts), 1);
`endif

      // Random traffic, with one reset in the middle.
      for (int i = 0; i < 3000; i++) begin
         rst = (i == 1500);
         fl  = ($urandom_range(0, 99) < 3);
         p   = ($urandom_range(0, 99) < 60);
         r   = ($urandom_range(0, 99) < 45);
         if (m_q.size() > 0 && $urandom_range(0, 99) < 85) rt = m_q[0].pred;
         else rt = 1'($urandom_range(0, 1));
         step(rst, p, 16'($urandom), 1'($urandom_range(0, 1)), r, rt, fl);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
